// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;
  localparam int SIZE_DEF = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic id_t;
endpackage

// File: rtl/mult_shift_add_step.sv
// Shift-add datapath: one multiplier bit per step; acc is the post-step sum.
// Latency: load on one edge, then one bit per step edge; no flow control of its own.
module mult_shift_add_step
  import mult_pkg::*;
#(
  parameter int size = SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [size-1:0]   a,
  input  logic [size-1:0]   b,
  output logic [2*size-1:0] acc,
  output logic              last,
  output logic              b_zero
);
  localparam int CW = $clog2(size + 1);

  logic [2*size-1:0] r_temp_a;
  logic [2*size-1:0] r_acc;
  logic [size-1:0]   r_temp_b;
  logic [CW-1:0]     r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_temp_a <= '0;
      r_temp_b <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_temp_a <= {{size{1'b0}}, a};
      r_temp_b <= b;
      r_acc    <= '0;
      r_cnt    <= CW'(size);
    end else if (step) begin
      r_acc    <= acc;
      r_temp_a <= r_temp_a << 1;
      r_temp_b <= r_temp_b >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // Exposing the updated sum lets the owner capture the product on the final step edge.
  assign acc    = r_temp_b[0] ? (r_acc + r_temp_a) : r_acc;
  assign last   = (r_cnt == CW'(1));
  assign b_zero = ((r_temp_b >> 1) == '0);
endmodule

// File: rtl/mult_seq_arb.sv
// Round-robin shared shift-add multiplier; MULT_SEQ_EARLY_EXIT_EN ends RUN once remaining b bits are zero.
// Latency: result valid size edges after accept (early exit: 1 + msb index of b); one product per size+2 cycles.
// Backpressure: DONE holds out/out_id until out_ready; req_ready stays low outside IDLE.
module mult_seq_arb
  import mult_pkg::*;
#(
  parameter int size = SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [size-1:0]   a0,
  input  logic [size-1:0]   b0,
  input  logic [size-1:0]   a1,
  input  logic [size-1:0]   b1,
  output logic [2*size-1:0] out,
  output logic              out_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rr;
  id_t               r_id;
  logic [2*size-1:0] r_out;
  id_t               r_out_id;
  id_t               w_gnt;
  logic              w_load;
  logic              w_step;
  logic              w_fin;
  logic [size-1:0]   w_a;
  logic [size-1:0]   w_b;
  logic [2*size-1:0] w_acc;
  logic              w_last;
  logic              w_b_zero;

  // The pointer only matters on a tie; a lone requester always wins.
  assign w_gnt = (&req_valid) ? r_rr : req_valid[1];
  assign w_a   = w_gnt ? a1 : a0;
  assign w_b   = w_gnt ? b1 : b0;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fin       = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if ((|req_valid) && rst_n) begin
          req_ready[w_gnt] = 1'b1;
          w_load           = 1'b1;
          w_state_nxt      = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
`ifdef MULT_SEQ_EARLY_EXIT_EN
        w_fin  = w_last | w_b_zero;
`else
        w_fin  = w_last;
`endif
        if (w_fin) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr     <= 1'b0;
      r_id     <= 1'b0;
      r_out    <= '0;
      r_out_id <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_rr <= ~w_gnt;
        r_id <= w_gnt;
      end
      if (w_fin) begin
        r_out    <= w_acc;
        r_out_id <= r_id;
      end
    end
  end

  mult_shift_add_step #(.size(size)) u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .step   (w_step),
    .a      (w_a),
    .b      (w_b),
    .acc    (w_acc),
    .last   (w_last),
    .b_zero (w_b_zero)
  );

  assign out    = r_out;
  assign out_id = r_out_id;
  assign busy   = (r_state != IDLE);
endmodule

// File: doc/mult_seq_arb.md
# mult_seq_arb

Sequential shift-add multiplier shared between two requesters. It arbitrates round-robin, accepts one operand pair, and iterates one multiplier bit per clock. It returns the 2*size-bit product with the requester's ID over a valid/ready result port. It replaces per-client combinational multipliers where area matters more than latency.

## Interface
- size, 8: operand width in bits; product is 2*size bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  bit i: requester i presents a0/b0 (i=0) or a1/b1 (i=1).
- req_ready  output  2  bit i: requester i's operands are accepted this cycle; at most one bit high.
- a0, b0  input  size each  requester 0 multiplicand, multiplier.
- a1, b1  input  size each  requester 1 multiplicand, multiplier.
- out  output  2*size  product.
- out_id  output  1  requester that owns `out`.
- out_valid  output  1  `out`/`out_id` valid.
- out_ready  input  1  consumer accepts result.
- busy  output  1  high in RUN and DONE.

## Operation
- States (shared enum): IDLE, RUN, DONE.
- **IDLE**
  - If no req_valid bit is set: stay.
  - Otherwise grant one requester by round-robin pointer `rr`. When both are valid, requester `rr` wins. A single valid requester is granted regardless of `rr`.
  - req_ready[g] is combinational in IDLE: high only for the granted valid requester. Low in all other states.
  - On the accept edge:
    - latch temp_a = zero-extended a_g (2*size bits), temp_b = b_g, acc = 0, cnt = size, id = g;
    - set rr = ~g;
    - go to RUN.
- **RUN**, each edge:
  - if temp_b[0], acc += temp_a (2*size-bit add, no overflow possible);
  - temp_a <<= 1, temp_b >>= 1, cnt -= 1;
  - on the edge where cnt was 1, load out = updated acc and out_id = id, and go to DONE.
- **DONE**
  - out_valid = 1.
  - out/out_id stay stable until out_valid && out_ready. On that edge go to IDLE.
  - No request is accepted in DONE.
- After the transfer, `out`/`out_id` keep their last value and out_valid is 0.
- Reset (any time, including mid-RUN or while DONE is stalled):
  - state = IDLE, rr = 0, out = 0, out_id = 0, out_valid = 0, req_ready = 0, busy = 0;
  - the in-flight operation is discarded with no result.
- Operand changes after acceptance do not affect the product.

## Timing
- Accept edge E: the edge where req_valid[g] && req_ready[g].
- RUN occupies the cycles between E and E+size. out_valid rises after edge E+size.
- With out_ready held high:
  - the result transfers on edge E+size+1;
  - IDLE follows, and the next accept is possible on edge E+size+2;
  - throughput is one product per size+2 cycles.
- out_ready low: DONE holds indefinitely; requesters see req_ready = 0.

## Configuration
- MULT_SEQ_EARLY_EXIT_EN
  - Defined: in RUN, the block also goes to DONE on the first edge where the shifted temp_b becomes 0. The product is already final at that point.
    - Minimum one RUN cycle; b = 0 gives out_valid after edge E+1.
    - Latency equals 1 + index of the highest set bit of b.
  - Undefined: always size RUN cycles.
  - Products are identical either way.

## Structure
- Package `mult_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - the requester-ID type (1 bit);
  - the default `size` constant, 8.
- Sub-module `mult_shift_add_step` holds the datapath:
  - registers temp_a, temp_b, acc and cnt;
  - inputs load, step, a, b; outputs acc, last, b_zero.
- The top level holds the FSM, the round-robin arbiter and the output register.

## Test plan
All scenarios use size = 8.
- **Single request:** req_valid = 01, a0 = 255, b0 = 255, out_ready = 1 → req_ready = 01 for one cycle; out = 65025, out_id = 0, out_valid for exactly one cycle, 8 cycles after accept.
- **Simultaneous requests:** both valid after reset (a0 = 3, b0 = 5, a1 = 7, b1 = 9) → requester 0 served first (out = 15); requester 1 served next (out = 63, out_id = 1); a third simultaneous pair goes to requester 0.
- **Backpressure:** out_ready = 0 for 20 cycles after out_valid → out and out_id stable, req_ready = 00 throughout; transfer on the first out_ready = 1 edge.
- **Zero and edges:** a = 0, b = 200 → 0; a = 200, b = 0 → 0; a = 1, b = 128 → 128.
  - With MULT_SEQ_EARLY_EXIT_EN: b = 0 → out_valid after 1 RUN cycle; b = 128 → after 8 RUN cycles; b = 1 → after 1 RUN cycle.
- **Reset mid-RUN:** assert rst_n = 0 four cycles after accepting 100 × 100 → outputs are reset values immediately and no out_valid appears. After release, a new request 12 × 12 returns 144.
- **Stability:** change a0/b0 during RUN → product matches the latched operands.
